// File: rtl/cache_arb_pkg.sv
// Shared types for the cache-to-memory-bus arbiter: bus opcodes, FSM states
// and request source encoding.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        MEM_OP_LOAD_WORD   = 2'd0,
        MEM_OP_LOAD_BLOCK  = 2'd1,
        MEM_OP_STORE_WORD  = 2'd2,
        MEM_OP_STORE_BLOCK = 2'd3
    } mem_op_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic ARB_SRC_ICACHE = 1'b0;
    localparam logic ARB_SRC_DCACHE = 1'b1;

    // The icache only ever loads; its block flag selects word vs block.
    function automatic mem_op_t icache_op(input logic block);
        return block ? MEM_OP_LOAD_BLOCK : MEM_OP_LOAD_WORD;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts dcache grants that bypassed a pending icache request; force_i is
// raised once the count reaches limit. Used only with ARB_STARVE_GUARD_EN.
module arb_starve_counter (
    input  logic       clk,
    input  logic       rstn,
    input  logic       inc,
    input  logic       clr,
    input  logic [3:0] limit,
    output logic       force_i
);

    logic [3:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != limit)) begin
            count <= count + 4'd1;
        end
    end

    assign force_i = (count == limit);

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache/dcache requests onto one memory-bus request channel.
// Optional icache starvation guard: define ARB_STARVE_GUARD_EN.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_req_valid,
    input  logic              i_req_block,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ready,
    input  logic              d_req_valid,
    input  logic [1:0]        d_req_op,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    output logic              bus_req_valid,
    output logic [1:0]        bus_req_op,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic              bus_req_src,
    input  logic              bus_req_ready,
    input  logic              bus_done,
    output logic              i_done,
    output logic              d_done,
    output logic              busy
);

    localparam logic [3:0] STARVE_LIMIT_4 = 4'(STARVE_LIMIT);

    arb_state_t state;
    mem_op_t    op_q;
    logic       force_i;
    logic       idle;
    logic       i_win;
    logic       d_win;

    // rstn gating keeps both readies low while reset is held.
    assign idle  = (state == ARB_IDLE) && rstn;
    assign i_win = idle && i_req_valid && (!d_req_valid || force_i);
    assign d_win = idle && d_req_valid && !i_win;

    assign i_req_ready = i_win;
    assign d_req_ready = d_win;
    assign bus_req_op  = op_q;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_counter u_starve (
        .clk     (clk),
        .rstn    (rstn),
        .inc     (d_win && i_req_valid),
        .clr     (i_win || ((state == ARB_IDLE) && !i_req_valid)),
        .limit   (STARVE_LIMIT_4),
        .force_i (force_i)
    );
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT_4;
    assign force_i      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ARB_IDLE;
            op_q          <= MEM_OP_LOAD_WORD;
            bus_req_addr  <= '0;
            bus_req_src   <= ARB_SRC_ICACHE;
            bus_req_valid <= 1'b0;
            i_done        <= 1'b0;
            d_done        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (i_win) begin
                        op_q          <= icache_op(i_req_block);
                        bus_req_addr  <= i_req_addr;
                        bus_req_src   <= ARB_SRC_ICACHE;
                        bus_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ARB_ISSUE;
                    end else if (d_win) begin
                        op_q          <= mem_op_t'(d_req_op);
                        bus_req_addr  <= d_req_addr;
                        bus_req_src   <= ARB_SRC_DCACHE;
                        bus_req_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        state         <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (bus_done) begin
                        i_done <= (bus_req_src == ARB_SRC_ICACHE);
                        d_done <= (bus_req_src == ARB_SRC_DCACHE);
                        state  <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    bus_req_valid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule
